// File: rtl/led_pulse_stretcher.sv
// Four independent LED pulse stretchers: each trigger produces 1-4 blinks of
// ON_CYCLES on / OFF_CYCLES off, with retrigger restarting the sequence.
module led_pulse_stretcher #(
   parameter int CNT_W      = 22,
   parameter int ON_CYCLES  = 2500000,
   parameter int OFF_CYCLES = 2500000
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [3:0] i_Event,
   input  logic [1:0] i_Blinks,
   output logic [3:0] o_LED,
   output logic [3:0] o_Busy
);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

   if (ON_CYCLES < 1 || OFF_CYCLES < 1 ||
       longint'(ON_CYCLES)  > (longint'(1) << CNT_W) ||
       longint'(OFF_CYCLES) > (longint'(1) << CNT_W)) begin : g_param_err
      $error("led_pulse_stretcher: ON_CYCLES/OFF_CYCLES must be in 1..2**CNT_W");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   for (genvar n = 0; n < 4; n++) begin : g_ch
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [1:0]       rem_q, rem_d;
      logic             led_q, busy_q;

      // A trigger in any state wins over the period-end transition.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         rem_d   = rem_q;
         if (i_Event[n]) begin
            state_d = S_ON;
            cnt_d   = '0;
            rem_d   = i_Blinks;
         end else begin
            case (state_q)
               S_ON: begin
                  if (cnt_q == ON_LAST) begin
                     cnt_d = '0;
                     if (rem_q == 2'd0) begin
                        state_d = S_IDLE;
                     end else begin
                        rem_d   = rem_q - 2'd1;
                        state_d = S_OFF;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               S_OFF: begin
                  if (cnt_q == OFF_LAST) begin
                     cnt_d   = '0;
                     state_d = S_ON;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
      end

      // Outputs are registered from the next state so they track state_q exactly.
      always_ff @(posedge i_Clk) begin
         if (!i_Rst_L) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= 2'd0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            led_q   <= (state_d == S_ON);
            busy_q  <= (state_d != S_IDLE);
         end
      end

      assign o_LED[n]  = led_q;
      assign o_Busy[n] = busy_q;
   end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON=4, OFF=3, CNT_W=4; expected
// outputs are queued with each stimulus cycle and checked one edge later.
module tb_led_pulse_stretcher;

   localparam int ONC  = 4;
   localparam int OFFC = 3;

   logic       i_Clk = 1'b0;
   logic       i_Rst_L;
   logic [3:0] i_Event;
   logic [1:0] i_Blinks;
   logic [3:0] o_LED;
   logic [3:0] o_Busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] led;
      logic [3:0] busy;
   } exp_t;

   exp_t sb_q[$];

   led_pulse_stretcher #(
      .CNT_W     (4),
      .ON_CYCLES (ONC),
      .OFF_CYCLES(OFFC)
   ) dut (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Event (i_Event),
      .i_Blinks(i_Blinks),
      .o_LED   (o_LED),
      .o_Busy  (o_Busy)
   );

   always #5 i_Clk = ~i_Clk;

   // rel = cycles since the trigger edge (output cycle minus trigger cycle).
   function automatic logic led_on(input int rel, input int b);
      int tot;
      tot = (b + 1) * ONC + b * OFFC;
      return (rel >= 1) && (rel <= tot) && (((rel - 1) % (ONC + OFFC)) < ONC);
   endfunction

   function automatic logic busy_on(input int rel, input int b);
      return (rel >= 1) && (rel <= (b + 1) * ONC + b * OFFC);
   endfunction

   task automatic cyc(input logic rst_l, input logic [3:0] ev, input logic [1:0] bl,
                      input logic [3:0] exp_led, input logic [3:0] exp_busy,
                      input string tag);
      exp_t e;
      i_Rst_L  = rst_l;
      i_Event  = ev;
      i_Blinks = bl;
      sb_q.push_back('{tag, exp_led, exp_busy});
      @(posedge i_Clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      assert ({o_LED, o_Busy} === {e.led, e.busy}) else begin
         errors++;
         $error("FAIL %s observed led=%b busy=%b expected led=%b busy=%b",
                e.tag, o_LED, o_Busy, e.led, e.busy);
      end
   endtask

   initial begin
      logic l;
      logic b;
      i_Rst_L  = 1'b0;
      i_Event  = 4'h0;
      i_Blinks = 2'd0;
      #2;

      // Reset with all events asserted
      cyc(1'b0, 4'hF, 2'd3, 4'h0, 4'h0, "reset_c0");
      cyc(1'b0, 4'hF, 2'd3, 4'h0, 4'h0, "reset_c1");
      cyc(1'b1, 4'h0, 2'd0, 4'h0, 4'h0, "reset_release");
      for (int c = 0; c < 3; c++) cyc(1'b1, 4'h0, 2'd0, 4'h0, 4'h0, "idle");

      // Single blink on channel 0, trigger at cycle 10
      for (int c = 0; c < 20; c++) begin
         l = led_on(c + 1 - 10, 0);
         b = busy_on(c + 1 - 10, 0);
         cyc(1'b1, (c == 10) ? 4'b0001 : 4'b0000, 2'd0, {3'b000, l}, {3'b000, b}, "single");
      end

      // Three blinks on channel 1; i_Blinks wiggles afterwards without effect
      for (int c = 0; c < 22; c++) begin
         l = led_on(c + 1, 2);
         b = busy_on(c + 1, 2);
         cyc(1'b1, (c == 0) ? 4'b0010 : 4'b0000, (c == 0) ? 2'd2 : c[1:0],
             {2'b00, l, 1'b0}, {2'b00, b, 1'b0}, "multi");
      end

      // Retrigger on channel 2 mid-ON stretches the pulse
      for (int c = 0; c < 12; c++) begin
         int tr;
         tr = (c >= 3) ? 3 : 0;
         l = led_on(c + 1 - tr, 0);
         cyc(1'b1, (c == 0 || c == 3) ? 4'b0100 : 4'b0000, 2'd0,
             {1'b0, l, 2'b00}, {1'b0, l, 2'b00}, "retrig");
      end

      // Retrigger exactly on the final ON cycle overrides the ON->OFF move
      for (int c = 0; c < 12; c++) begin
         if (c < 4) begin
            l = led_on(c + 1, 1);
            b = busy_on(c + 1, 1);
         end else begin
            l = led_on(c + 1 - 4, 0);
            b = busy_on(c + 1 - 4, 0);
         end
         cyc(1'b1, (c == 0 || c == 4) ? 4'b1000 : 4'b0000, (c == 0) ? 2'd1 : 2'd0,
             {l, 3'b000}, {b, 3'b000}, "retrig_at_end");
      end

      // Simultaneous trigger on channels 0 and 3
      for (int c = 0; c < 15; c++) begin
         l = led_on(c + 1, 1);
         b = busy_on(c + 1, 1);
         cyc(1'b1, (c == 0) ? 4'b1001 : 4'b0000, (c < 2) ? 2'd1 : 2'd3,
             {l, 2'b00, l}, {b, 2'b00, b}, "simul");
      end

      // Reset mid-sequence together with a retrigger
      for (int c = 0; c < 26; c++) begin
         if (c < 6) begin
            l = led_on(c + 1, 2);
            b = busy_on(c + 1, 2);
         end else begin
            l = 1'b0;
            b = 1'b0;
         end
         cyc((c == 6) ? 1'b0 : 1'b1, (c == 0 || c == 6) ? 4'b0010 : 4'b0000,
             2'd2, {2'b00, l, 1'b0}, {2'b00, b, 1'b0}, "reset_mid");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pulse_stretcher.md
LED_PULSE_STRETCHER -- requirements
Module: led_pulse_stretcher

Interface
REQ-001 Parameter CNT_W, default 22, SHALL set the width of each channel's period counter.
REQ-002 Parameter ON_CYCLES, default 2500000, SHALL set the LED-on period length in clock cycles (100 ms at 25 MHz).
REQ-003 Parameter OFF_CYCLES, default 2500000, SHALL set the LED-off gap between blinks in clock cycles.
REQ-004 i_Clk  input  1  SHALL be the single clock for the block; all state changes on its rising edge.
REQ-005 i_Rst_L  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 i_Event  input  4  SHALL carry per-channel single-cycle trigger requests, active-high.
REQ-007 i_Blinks  input  2  SHALL give the blink count minus one (0 = 1 blink, 3 = 4 blinks), shared by all channels and sampled per channel on trigger.
REQ-008 o_LED  output  4  SHALL carry the per-channel stretched LED drive, active-high.
REQ-009 o_Busy  output  4  SHALL flag each channel not in IDLE.

Function
REQ-010 The block SHALL contain four independent identical channels; channel n uses only i_Event[n], o_LED[n] and o_Busy[n].
REQ-011 Each channel SHALL run an FSM with states IDLE, ON and OFF, plus a CNT_W-bit counter and a 2-bit remaining-blinks register.
REQ-012 In IDLE with i_Event[n]=1, the channel SHALL load remaining = i_Blinks, clear the counter, and enter ON at the next edge.
REQ-013 In ON, the counter SHALL increment each cycle; at counter == ON_CYCLES-1 it SHALL clear; the channel SHALL go to IDLE if remaining == 0, else decrement remaining and go to OFF.
REQ-014 In OFF, the counter SHALL increment each cycle; at counter == OFF_CYCLES-1 it SHALL clear and the channel SHALL go to ON.
REQ-015 o_LED[n] SHALL be 1 exactly when channel n is in ON, so latency from i_Event to o_LED is one cycle.
REQ-016 o_Busy[n] SHALL be 1 exactly when channel n is not in IDLE.
REQ-017 Outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-018 Retrigger: i_Event[n]=1 while in ON or OFF SHALL reload remaining from i_Blinks, clear the counter and enter ON at the next edge.
REQ-019 Retrigger SHALL take priority over the period-end transition occurring in the same cycle.
REQ-020 A trigger at cycle t with i_Blinks = B SHALL keep o_Busy high for exactly (B+1)*ON_CYCLES + B*OFF_CYCLES cycles, starting at t+1.
REQ-021 Simultaneous events on several channels SHALL each sample the same i_Blinks value and run identical, independent sequences.
REQ-022 The counter SHALL never exceed max(ON_CYCLES, OFF_CYCLES)-1 and SHALL never wrap.
REQ-023 Elaboration SHALL fail if ON_CYCLES < 1, if OFF_CYCLES < 1, or if either value exceeds 2^CNT_W.
REQ-024 Changes on i_Blinks while a channel is busy SHALL have no effect unless a retrigger occurs.

Reset
REQ-025 With i_Rst_L=0 at a rising edge, every channel SHALL enter IDLE with counter = 0 and remaining = 0.
REQ-026 Reset values SHALL be o_LED = 4'b0000 and o_Busy = 4'b0000, visible from the cycle after the reset edge.
REQ-027 Reset SHALL override any i_Event in the same cycle; that event is discarded.
REQ-028 Reset asserted mid-sequence (ON or OFF) SHALL abort the sequence; no blink SHALL resume after release.

Verification (bench parameters: ON_CYCLES=4, OFF_CYCLES=3, CNT_W=4)
REQ-029 Reset: i_Rst_L=0 for 2 cycles with i_Event=4'hF -> o_LED=0, o_Busy=0 throughout and on the first cycle after release.
REQ-030 Single blink: i_Event[0] pulse at cycle 10 with i_Blinks=0 -> o_LED[0]=1 and o_Busy[0]=1 in cycles 11-14, both 0 from cycle 15.
REQ-031 Multi-blink: i_Event[1] at cycle 0 with i_Blinks=2 -> o_LED[1] high in 1-4, low in 5-7, high in 8-11, low in 12-14, high in 15-18; o_Busy[1] high in 1-18, 0 at cycle 19.
REQ-032 Retrigger: i_Event[2] at cycle 0, second i_Event[2] at cycle 3 (i_Blinks=0) -> o_LED[2] continuously high in cycles 1-7, low from cycle 8.
REQ-033 Simultaneous: i_Event=4'b1001 at cycle 0 with i_Blinks=1, i_Blinks changed to 3 at cycle 2 -> channels 0 and 3 identical, high 1-4, low 5-7, high 8-11, idle at 12; channels 1 and 2 stay 0.
REQ-034 Reset mid-operation: i_Rst_L=0 at cycle 6 of the REQ-031 sequence, together with i_Event[1]=1 -> o_LED[1]=0 and o_Busy[1]=0 from cycle 7, no further activity after release.
